// File: rtl/mmio_pkg.sv
// Shared address map, STATUS layout and decode helper for the MMIO data bus.
package mmio_pkg;

  // Register addresses (word aligned, low 16 bits of the byte address)
  localparam logic [15:0] ADDR_TIMER  = 16'h8000;
  localparam logic [15:0] ADDR_TCMP   = 16'h8004;
  localparam logic [15:0] ADDR_STATUS = 16'h8008;
  localparam logic [15:0] ADDR_TXDATA = 16'h800C;
  localparam logic [15:0] ADDR_LED    = 16'h8010;

  // STATUS bit positions
  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_CNT_LO = 4;
  localparam int ST_CNT_HI = 7;
  localparam int ST_HIT    = 8;
  localparam int ST_OVF    = 9;

  localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

  // Which target an access selects
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_TIMER,
    SEL_TCMP,
    SEL_STATUS,
    SEL_TXDATA,
    SEL_LED
  } sel_e;

  // Address decode: upper half must be zero, byte offset within a word is ignored
  function automatic sel_e decode_addr(input logic [31:0] addr, input logic [16:0] ram_bytes);
    logic [15:0] a;
    sel_e        sel;
    a   = {addr[15:2], 2'b00};
    sel = SEL_NONE;
    if (addr[31:16] != 16'h0000) begin
      sel = SEL_NONE;
    end else if ({1'b0, a} < ram_bytes) begin
      sel = SEL_RAM;
    end else begin
      case (a)
        ADDR_TIMER:  sel = SEL_TIMER;
        ADDR_TCMP:   sel = SEL_TCMP;
        ADDR_STATUS: sel = SEL_STATUS;
        ADDR_TXDATA: sel = SEL_TXDATA;
        ADDR_LED:    sel = SEL_LED;
        default:     sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

  // FIFO occupancy as shown in STATUS, clamped to the 4-bit field
  function automatic logic [3:0] sat_count(input logic [31:0] c);
    return (c > 32'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/mmio_data_bus_sync_fifo.sv
// Synchronous circular FIFO; head is zero while empty so the consumer never sees stale data.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_wptr;
  logic [PW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_head    = o_empty ? '0 : r_mem[r_rptr];

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (w_do_push && !rst) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/mmio_data_bus.sv
// Data-side MMIO bus for the single-cycle core: RAM, timer/compare, TX FIFO and LED register.
module mmio_data_bus
  import mmio_pkg::*;
#(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ram_ena,
  input  logic        data_ram_wea,
  input  logic [31:0] AluOut,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] led
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [16:0] RAM_BYTES = 17'(4 * RAM_WORDS);

  logic [31:0]       r_ram [RAM_WORDS];
  logic [31:0]       r_timer;
  logic [31:0]       r_tcmp;
  logic              r_hit;
  logic              r_ovf;
  logic [15:0]       r_led;

  sel_e              w_sel;
  logic              w_wr;
  logic              w_wr_ram;
  logic              w_wr_tcmp;
  logic              w_wr_status;
  logic              w_wr_tx;
  logic              w_wr_led;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [7:0]        w_head;
  logic [31:0]       w_status;

  assign w_sel       = data_ram_ena ? decode_addr(AluOut, RAM_BYTES) : SEL_NONE;
  assign w_wr        = data_ram_ena & data_ram_wea;
  assign w_wr_ram    = w_wr & (w_sel == SEL_RAM);
  assign w_wr_tcmp   = w_wr & (w_sel == SEL_TCMP);
  assign w_wr_status = w_wr & (w_sel == SEL_STATUS);
  assign w_wr_tx     = w_wr & (w_sel == SEL_TXDATA);
  assign w_wr_led    = w_wr & (w_sel == SEL_LED);
  assign w_ram_idx   = AluOut[RAM_AW+1:2];

  assign w_pop    = tx_valid & tx_ready;
  assign tx_valid = ~w_empty;
  assign tx_data  = w_head;
  assign led      = r_led;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_wr_tx),
    .i_pop   (w_pop),
    .i_wdata (WriteData[7:0]),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // STATUS view of the state held before this cycle's updates
  always_comb begin
    w_status                      = '0;
    w_status[ST_FULL]             = w_full;
    w_status[ST_EMPTY]            = w_empty;
    w_status[ST_CNT_HI:ST_CNT_LO] = sat_count(32'(w_count));
    w_status[ST_HIT]              = r_hit;
    w_status[ST_OVF]              = r_ovf;
  end

  // Zero-latency load mux; disabled or unmapped accesses read as zero
  always_comb begin
    ReadData = '0;
    case (w_sel)
      SEL_RAM:    ReadData = r_ram[w_ram_idx];
      SEL_TIMER:  ReadData = r_timer;
      SEL_TCMP:   ReadData = r_tcmp;
      SEL_STATUS: ReadData = w_status;
      SEL_LED:    ReadData = {16'h0000, r_led};
      default:    ReadData = '0;
    endcase
  end

  // Word store into RAM; a store coinciding with reset is discarded
  always_ff @(posedge clk) begin
    if (w_wr_ram && !rst) r_ram[w_ram_idx] <= WriteData;
  end

  // Timer, compare, sticky flags (set beats W1C) and LED register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
      r_tcmp  <= TCMP_RST;
      r_hit   <= 1'b0;
      r_ovf   <= 1'b0;
      r_led   <= '0;
    end else begin
      r_timer <= r_timer + 32'd1;
      if (w_wr_tcmp) r_tcmp <= WriteData;
      if (w_wr_led)  r_led  <= WriteData[15:0];
      r_hit <= (r_timer == r_tcmp) | (r_hit & ~(w_wr_status & WriteData[ST_HIT]));
      r_ovf <= (w_wr_tx & w_full)  | (r_ovf & ~(w_wr_status & WriteData[ST_OVF]));
    end
  end

endmodule

// File: tb/tb_mmio_data_bus.sv
// Randomized and directed bench for mmio_data_bus against a transaction-level reference model.
module tb_mmio_data_bus;

  localparam int          RW        = 256;
  localparam int          FD        = 8;
  localparam logic [31:0] A_TIMER   = 32'h8000;
  localparam logic [31:0] A_TCMP    = 32'h8004;
  localparam logic [31:0] A_STATUS  = 32'h8008;
  localparam logic [31:0] A_TXDATA  = 32'h800C;
  localparam logic [31:0] A_LED     = 32'h8010;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_ram_ena;
  logic        data_ram_wea;
  logic [31:0] AluOut;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] led;

  mmio_data_bus #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_ram_ena (data_ram_ena),
    .data_ram_wea (data_ram_wea),
    .AluOut       (AluOut),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .led          (led)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [31:0] m_timer;
  logic [31:0] m_tcmp;
  bit          m_hit;
  bit          m_ovf;
  logic [15:0] m_led;
  logic [7:0]  m_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    int          n;
    n       = m_q.size();
    s       = '0;
    s[0]    = (n == FD);
    s[1]    = (n == 0);
    s[7:4]  = (n > 15) ? 4'hF : 4'(n);
    s[8]    = m_hit;
    s[9]    = m_ovf;
    return s;
  endfunction

  function automatic logic [31:0] model_read(input logic ena, input logic [31:0] addr, output bit known);
    logic [31:0] a;
    known = 1'b1;
    if (!ena || addr[31:16] != 16'h0) return 32'h0;
    a = addr & 32'h0000_FFFC;
    if (a < 4 * RW) begin
      if (m_ram.exists(int'(a >> 2))) return m_ram[int'(a >> 2)];
      known = 1'b0;
      return 32'h0;
    end
    if (a == A_TIMER)  return m_timer;
    if (a == A_TCMP)   return m_tcmp;
    if (a == A_STATUS) return model_status();
    if (a == A_LED)    return {16'h0, m_led};
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_timer = 0;
    m_tcmp  = 32'hFFFF_FFFF;
    m_hit   = 0;
    m_ovf   = 0;
    m_led   = 0;
    m_q.delete();
  endtask

  task automatic model_update(input logic ena, input logic wea, input logic [31:0] addr,
                              input logic [31:0] wd, input logic rdy);
    bit          wr;
    logic [31:0] a;
    int          n;
    bit          push_req;
    wr       = ena && wea && (addr[31:16] == 16'h0);
    a        = addr & 32'h0000_FFFC;
    n        = m_q.size();
    push_req = wr && (a == A_TXDATA);
    m_hit    = (m_timer == m_tcmp) || (m_hit && !(wr && a == A_STATUS && wd[8]));
    m_ovf    = (push_req && n == FD) || (m_ovf && !(wr && a == A_STATUS && wd[9]));
    if (rdy && n > 0) void'(m_q.pop_front());
    if (push_req && n < FD) m_q.push_back(wd[7:0]);
    if (wr && a < 4 * RW) m_ram[int'(a >> 2)] = wd;
    if (wr && a == A_TCMP) m_tcmp = wd;
    if (wr && a == A_LED) m_led = wd[15:0];
    m_timer = m_timer + 1;
  endtask

  // One bus cycle: drive, check all outputs against the model, advance model and clock
  task automatic step(input logic ena, input logic wea, input logic [31:0] addr,
                      input logic [31:0] wd, input logic rdy, output logic [31:0] rd);
    bit          known;
    logic [31:0] exp;
    data_ram_ena = ena;
    data_ram_wea = wea;
    AluOut       = addr;
    WriteData    = wd;
    tx_ready     = rdy;
    #1;
    rd  = ReadData;
    exp = model_read(ena, addr, known);
    if (known) chk("rdata", rd, exp);
    chk("tx_valid", {31'h0, tx_valid}, {31'h0, m_q.size() > 0});
    chk("tx_data", {24'h0, tx_data}, {24'h0, (m_q.size() > 0) ? m_q[0] : 8'h00});
    chk("led", {16'h0, led}, {16'h0, m_led});
    model_update(ena, wea, addr, wd, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    data_ram_ena = 1'b0;
    data_ram_wea = 1'b0;
    tx_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  exp_seq [$];
    int          n;
    int          lim;
    AluOut    = '0;
    WriteData = '0;
    do_reset();

    // Reset state
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    step(1, 0, A_STATUS, 0, 0, rd);
    chk("rst_status", rd, 32'h0000_0002);
    step(1, 0, A_TCMP, 0, 0, rd);
    chk("rst_tcmp", rd, 32'hFFFF_FFFF);

    // Timer compare: TCMP written in the first cycle after reset
    do_reset();
    step(1, 1, A_TCMP, 32'd20, 0, rd);
    for (int c = 1; c <= 24; c++) begin
      step(1, 0, A_STATUS, 0, 0, rd);
      if (c == 20) chk("hit_before", {31'h0, rd[8]}, 32'h0);
      if (c == 21) chk("hit_after", {31'h0, rd[8]}, 32'h1);
      if (c == 24) chk("hit_sticky", {31'h0, rd[8]}, 32'h1);
    end
    step(1, 1, A_STATUS, 32'h100, 0, rd);
    step(1, 0, A_STATUS, 0, 0, rd);
    chk("hit_clear", {31'h0, rd[8]}, 32'h0);
    step(1, 1, A_TCMP, m_timer + 32'd5, 0, rd);
    lim = 0;
    while (m_timer != m_tcmp && lim < 20) begin
      step(1, 0, A_TIMER, 0, 0, rd);
      lim++;
    end
    chk("hit_wait", lim, 4);
    step(1, 1, A_STATUS, 32'h100, 0, rd);
    step(1, 0, A_STATUS, 0, 0, rd);
    chk("hit_set_wins", {31'h0, rd[8]}, 32'h1);

    // RAM and access rules
    step(1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, rd);
    step(1, 0, 32'h0000_0010, 0, 0, rd);
    chk("ram_rd", rd, 32'hDEAD_BEEF);
    step(1, 0, 32'h0000_0013, 0, 0, rd);
    chk("ram_rd_bytebits", rd, 32'hDEAD_BEEF);
    step(0, 0, 32'h0000_0014, 0, 0, rd);
    chk("ram_disabled", rd, 32'h0);
    step(1, 0, 32'h0001_0010, 0, 0, rd);
    chk("ram_unmapped", rd, 32'h0);
    step(1, 1, 32'h0001_0010, 32'h1234_5678, 0, rd);
    step(1, 0, 32'h0000_0010, 0, 0, rd);
    chk("unmapped_wr_ignored", rd, 32'hDEAD_BEEF);

    // FIFO fill with overflow, then drain
    for (int i = 1; i <= 9; i++) step(1, 1, A_TXDATA, 32'(i), 0, rd);
    step(1, 0, A_STATUS, 0, 0, rd);
    chk("fill_status", rd & 32'h2F3, 32'h281);
    step(1, 0, A_TXDATA, 0, 0, rd);
    chk("txdata_read_zero", rd, 32'h0);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (tx_valid) begin
        chk("drain_seq", {24'h0, tx_data}, 32'(n + 1));
        n++;
      end
      step(0, 0, 0, 0, 1, rd);
    end
    chk("drain_len", n, 8);

    // Simultaneous push and pop with three entries held
    step(1, 1, A_STATUS, 32'h200, 0, rd);
    for (int i = 1; i <= 3; i++) step(1, 1, A_TXDATA, 32'hA0 + 32'(i), 0, rd);
    step(1, 1, A_TXDATA, 32'hA4, 1, rd);
    step(1, 0, A_STATUS, 0, 0, rd);
    chk("pp_count", {28'h0, rd[7:4]}, 32'h3);
    chk("pp_no_ovf", {31'h0, rd[9]}, 32'h0);
    exp_seq = '{8'hA2, 8'hA3, 8'hA4};
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (tx_valid && n < 3) begin
        chk("pp_order", {24'h0, tx_data}, {24'h0, exp_seq[n]});
        n++;
      end
      step(0, 0, 0, 0, 1, rd);
    end
    chk("pp_len", n, 3);

    // Full FIFO with push and pop together: push dropped
    for (int i = 0; i < 8; i++) step(1, 1, A_TXDATA, 32'hB0 + 32'(i), 0, rd);
    step(1, 1, A_TXDATA, 32'hC0, 1, rd);
    step(1, 0, A_STATUS, 0, 0, rd);
    chk("full_pp_status", rd & 32'h2F3, 32'h270);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 1, rd);
    chk("full_pp_empty", {31'h0, tx_valid}, 32'h0);

    // LED register and mid-run reset
    step(1, 1, A_LED, 32'hFFFF_1234, 0, rd);
    chk("led_out", {16'h0, led}, 32'h1234);
    step(1, 0, A_LED, 0, 0, rd);
    chk("led_rd", rd, 32'h0000_1234);
    step(1, 1, A_TXDATA, 32'h55, 0, rd);
    do_reset();
    chk("midrst_led", {16'h0, led}, 32'h0);
    chk("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);

    // Randomized traffic
    for (int t = 0; t < 800; t++) begin
      logic        ena;
      logic        wea;
      logic        rdy;
      logic [31:0] addr;
      logic [31:0] wd;
      int          pick;
      ena  = ($urandom_range(0, 7) != 0);
      wea  = $urandom_range(0, 1);
      rdy  = ($urandom_range(0, 2) == 0);
      wd   = $urandom;
      pick = $urandom_range(0, 10);
      case (pick)
        0, 1, 2: addr = 32'h100 + 32'($urandom_range(0, 31));
        3:       addr = A_TIMER;
        4: begin
          addr = A_TCMP;
          wd   = m_timer + 32'($urandom_range(0, 6));
        end
        5:       addr = A_STATUS;
        6, 7:    addr = A_TXDATA;
        8:       addr = A_LED | 32'($urandom_range(0, 3));
        9:       addr = {16'($urandom_range(1, 65535)), 16'h8010};
        default: addr = ($urandom_range(0, 1) != 0) ? 32'h8020 : 32'h0800;
      endcase
      step(ena, wea, addr, wd, rdy, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_data_bus.md
# mmio_data_bus

Memory-mapped data-side bus that sits directly downstream of the single-cycle MIPS core's data port. It consumes the core's `AluOut` (address), `WriteData`, `data_ram_ena` and `data_ram_wea`, and returns `ReadData` in the same cycle. It contains:
- a word-addressed data RAM;
- a free-running timer with compare flag;
- a byte-wide TX FIFO with valid/ready drain toward a serial transmitter;
- an LED output register.

## Interface
Parameters:
- `RAM_WORDS`, 256: data RAM depth in 32-bit words (power of two).
- `FIFO_DEPTH`, 8: TX FIFO entries (power of two, ≥2).

Ports:
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `data_ram_ena` in 1: access enable from the core.
- `data_ram_wea` in 1: write strobe; only acts when `data_ram_ena`=1.
- `AluOut` in 32: byte address from the core.
- `WriteData` in 32: store data from the core.
- `ReadData` out 32: load data to the core; combinational from address and current state.
- `tx_data` out 8: FIFO head byte.
- `tx_valid` out 1: FIFO non-empty.
- `tx_ready` in 1: downstream accepts `tx_data` when `tx_valid`&`tx_ready`.
- `led` out 16: LED register.

## Operation
Address map. Decode uses `AluOut[15:0]`. `AluOut[31:16]` must be zero, otherwise the access is unmapped. Bits [1:0] are ignored (word access only).
- 0x0000 to 4·RAM_WORDS−4: RAM. Read is combinational; write is synchronous, full word.
- 0x8000 TIMER: read-only. 32-bit count, +1 every cycle, wraps 0xFFFF_FFFF→0.
- 0x8004 TCMP: read/write compare value.
- 0x8008 STATUS (read):
  - bit0 fifo_full
  - bit1 fifo_empty
  - bits[7:4] fifo_count (saturates display at 15)
  - bit8 timer_hit
  - bit9 tx_overflow
  - other bits 0
- STATUS write: write-1-to-clear on bits 8 and 9; all other bits ignored.
- 0x800C TXDATA: write pushes `WriteData[7:0]`; read returns 0.
- 0x8010 LED: read/write; `WriteData[15:0]`, upper bits read 0.

Access rules:
- Unmapped or disabled (`data_ram_ena`=0) reads return 0x0000_0000.
- Unmapped writes are ignored.

Timer:
- timer_hit sets in the cycle after TIMER == TCMP; it is sticky.
- If a set and a W1C clear of timer_hit occur in the same cycle, the set wins.

TX FIFO:
- Circular buffer with read pointer, write pointer and count (log2(FIFO_DEPTH)+1 bits).
- Push occurs when a TXDATA write happens and count < FIFO_DEPTH.
- A push while full is dropped and sets tx_overflow, even if a pop occurs in the same cycle.
- Pop occurs on `tx_valid`&`tx_ready`.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.

Reset values:
- TIMER=0, TCMP=0xFFFF_FFFF, timer_hit=0, tx_overflow=0, led=0.
- FIFO empty: `tx_valid`=0, count=0, `tx_data`=0.
- RAM contents are not reset.
- Reset mid-operation discards FIFO contents and any write in that cycle.

## Timing
- Loads: `ReadData` valid in the same cycle as the address (zero latency), as required by the single-cycle core.
- Stores: take effect at the end-of-cycle edge. A load of the same address in the next cycle returns the new value.
- Reading STATUS reflects state before the current cycle's push, pop or clear.
- `tx_valid` rises one cycle after a push into an empty FIFO.
- `tx_data` is the head entry, stable while `tx_valid`&!`tx_ready`.
- The FIFO shows no pass-through: a push and an empty-state pop cannot occur together.

## Structure
- Package `mmio_pkg`:
  - address constants (ADDR_TIMER, ADDR_TCMP, ADDR_STATUS, ADDR_TXDATA, ADDR_LED);
  - STATUS bit-index constants;
  - TCMP reset constant.
- Sub-module `sync_fifo` (WIDTH, DEPTH): push/pop/full/empty/count/head. Instantiated once for TX.
- Decode, RAM array, timer and registers live in the top.

## Test plan
- Reset: assert `rst` 2 cycles → `led`=0, `tx_valid`=0, STATUS reads 0x0000_0002, TCMP reads 0xFFFF_FFFF.
- RAM: store 0xDEAD_BEEF at 0x0010, then load 0x0010 → 0xDEAD_BEEF. Load 0x0014 with `data_ram_ena`=0 → 0. Load 0x0001_0010 → 0.
- Timer: write TCMP=20 right after reset → STATUS bit8 is 0 before cycle 21 and 1 from then on. Write STATUS 0x100 → bit8 clears. Clear coinciding with a hit → bit8 stays 1.
- FIFO fill: `tx_ready`=0, push 0x01..0x09 → STATUS count=8, full=1, overflow=1. Then `tx_ready`=1 → `tx_data` sequence 0x01..0x08, `tx_valid` falls after 8 cycles.
- Simultaneous: FIFO holding 3 entries, push plus pop in the same cycle → count stays 3, order preserved. Full FIFO with push plus pop → push dropped, overflow set, count 7.
- LED: write 0xFFFF_1234 to 0x8010 → `led`=0x1234 next cycle, read returns 0x0000_1234. Reset mid-run → `led`=0.
